// File: rtl/regfile_issue.sv
// regfile_issue: four-entry 8-bit register file with an in-order issue stage
// for an external two-stage ALU.
//
// Instructions are accepted one per cycle. An ALU op latches its operands and
// its control code into the registered alu_a/alu_b/alu_ctr outputs. ALU ops and
// LDI are tracked by a 3-stage scoreboard and write the register file when they
// leave the last stage. There is no forwarding, so an ALU op that reads a
// register with a write still in flight is held off with instr_ready=0.
// Illegal opcodes are consumed without effect apart from setting a sticky err.
//
// Ports
//   ck          clock, rising edge
//   rst_n       asynchronous active-low reset
//   instr_valid instruction offered this cycle
//   instr[15:0] op=[15:12] rd=[11:10] ra=[9:8] rb=[7:6] imm=[7:0]
//   instr_ready instruction is taken at the next edge if instr_valid=1
//   alu_a/alu_b registered operands to the ALU
//   alu_ctr     registered ALU control code (the opcode)
//   alu_o       ALU result, valid when the issuing entry leaves stage 3
//   rd_sel      debug readback select
//   rd_data     combinational read of rf[rd_sel]
//   err         sticky illegal-opcode flag
module regfile_issue (
  input  logic        ck,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_ctr,
  input  logic [7:0]  alu_o,
  input  logic [1:0]  rd_sel,
  output logic [7:0]  rd_data,
  output logic        err
);

  typedef struct packed {
    logic       valid;
    logic [1:0] rd;
    logic       is_ldi;
    logic [7:0] imm;
  } sb_entry_t;

  logic [3:0] op;
  logic [1:0] rd;
  logic [1:0] ra;
  logic [1:0] rb;
  logic [7:0] imm;

  logic is_alu;
  logic is_unary;
  logic is_ldi;
  logic is_illegal;
  logic hazard;
  logic accept;

  sb_entry_t sb1;
  sb_entry_t sb2;
  sb_entry_t sb3;
  sb_entry_t sb_new;

  logic [7:0] rf [4];
  logic [7:0] wb_data;

  // rb shares bits with imm; it only matters for binary ALU ops.
  assign op  = instr[15:12];
  assign rd  = instr[11:10];
  assign ra  = instr[9:8];
  assign rb  = instr[7:6];
  assign imm = instr[7:0];

  always_comb begin
    is_alu     = 1'b0;
    is_unary   = 1'b0;
    is_ldi     = 1'b0;
    is_illegal = 1'b0;
    case (op)
      4'b0000, 4'b0001: is_alu = 1'b1;
      4'b0010:          is_ldi = 1'b1;
      4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111: is_illegal = 1'b1;
      default: begin
        // 1000..1111
        is_alu   = 1'b1;
        is_unary = (op >= 4'b1011);
      end
    endcase
  end

  // RAW check against every in-flight writer. Only ALU ops read the register
  // file, so LDI and illegal ops never stall. WAW is deliberately ignored:
  // writes retire in order, so the youngest writer lands last.
  always_comb begin
    hazard = 1'b0;
    if (is_alu) begin
      if (sb1.valid && (sb1.rd == ra || (!is_unary && sb1.rd == rb))) hazard = 1'b1;
      if (sb2.valid && (sb2.rd == ra || (!is_unary && sb2.rd == rb))) hazard = 1'b1;
      if (sb3.valid && (sb3.rd == ra || (!is_unary && sb3.rd == rb))) hazard = 1'b1;
    end
  end

  assign instr_ready = !(instr_valid && hazard);
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    sb_new        = '0;
    sb_new.valid  = accept && (is_alu || is_ldi);
    sb_new.rd     = rd;
    sb_new.is_ldi = is_ldi;
    sb_new.imm    = is_ldi ? imm : 8'h00;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      sb1 <= '0;
      sb2 <= '0;
      sb3 <= '0;
    end else begin
      sb1 <= sb_new;
      sb2 <= sb1;
      sb3 <= sb2;
    end
  end

  // The entry leaving stage 3 carries either its own immediate or the ALU
  // result for the operands issued three edges earlier.
  assign wb_data = sb3.is_ldi ? sb3.imm : alu_o;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      rf[0] <= 8'h00;
      rf[1] <= 8'h00;
      rf[2] <= 8'h00;
      rf[3] <= 8'h00;
    end else if (sb3.valid) begin
      rf[sb3.rd] <= wb_data;
    end
  end

  // Operands are read from rf before the accepting edge; a retirement at the
  // same edge is not visible to them.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= 8'h00;
      alu_b   <= 8'h00;
      alu_ctr <= 4'h0;
    end else if (accept && is_alu) begin
      alu_a   <= rf[ra];
      alu_b   <= rf[rb];
      alu_ctr <= op;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept && is_illegal) begin
      err <= 1'b1;
    end
  end

  assign rd_data = rf[rd_sel];

endmodule

// File: tb/tb_regfile_issue.sv
// Bench for regfile_issue: directed scenarios with hand-worked expectations,
// followed by a random instruction stream checked against an architectural
// model that predicts each acceptance edge from register readiness.
module tb_regfile_issue;

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        instr_ready;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_ctr;
  logic [7:0]  alu_o;
  logic [1:0]  rd_sel = 2'd0;
  logic [7:0]  rd_data;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  regfile_issue dut (
    .ck          (ck),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctr     (alu_ctr),
    .alu_o       (alu_o),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data),
    .err         (err)
  );

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  function automatic logic [7:0] alu_f(input logic [3:0] c, input logic [7:0] a,
                                       input logic [7:0] b);
    case (c)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h8:    return a & b;
      4'h9:    return a | b;
      4'hA:    return a ^ b;
      4'hB:    return ~a;
      4'hC:    return {a[6:0], 1'b0};
      4'hD:    return {1'b0, a[7:1]};
      4'hE:    return a + 8'h01;
      4'hF:    return {a[6:0], a[7]};
      default: return 8'h00;
    endcase
  endfunction

  // Downstream ALU: registers a/b/ctr one edge after issue, result one edge later.
  logic [7:0] xa = 8'h00;
  logic [7:0] xb = 8'h00;
  logic [3:0] xc = 4'h0;
  logic [7:0] xres = 8'h00;
  always @(posedge ck) begin
    xa   <= alu_a;
    xb   <= alu_b;
    xc   <= alu_ctr;
    xres <= alu_f(xc, xa, xb);
  end
  assign alu_o = xres;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_rf(input logic [1:0] idx, input logic [7:0] exp, input string tag);
    rd_sel = idx;
    #1;
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  // Called at a negedge. Returns at the negedge after the accepting edge with
  // acc = that edge number, or acc = -1 if the offer was never taken.
  task automatic issue(input logic [15:0] w, output int acc);
    acc = -1;
    instr = w;
    instr_valid = 1'b1;
    for (int t = 0; t < 16 && acc < 0; t++) begin
      #1;
      if (instr_ready) acc = cyc + 1;
      @(negedge ck);
    end
    instr_valid = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    for (int t = 0; t < 200 && cyc < n; t++) @(negedge ck);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  int c0, k1, k2, ka, kb, kc, kr, ki, ks, acc;
  logic [7:0] mrf [4];
  int rdy_at [4];
  int stall_exp, stall_obs, o, e;
  bit ill_seen, is_alu, is_un;
  logic [3:0] op;
  logic [1:0] rd, ra, rb;
  logic [7:0] imm;

  initial begin
    // Reset state, checked while rst_n is held low.
    #2;
    chk_rf(0, 8'h00, "rst_rf0");
    chk_rf(1, 8'h00, "rst_rf1");
    chk_rf(2, 8'h00, "rst_rf2");
    chk_rf(3, 8'h00, "rst_rf3");
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_b", 32'(alu_b), 0);
    chk("rst_alu_ctr", 32'(alu_ctr), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge ck);
    @(negedge ck);
    rst_n = 1'b1;
    @(negedge ck);
    chk("ready_after_rst", 32'(instr_ready), 1);

    // LDI r1,0x3C ; LDI r2,0x05 back-to-back, then ADD r3=r1+r2.
    c0 = cyc;
    issue(16'h243C, k1);
    chk("ldi1_acc", k1, c0 + 1);
    issue(16'h2805, k2);
    chk("ldi2_b2b", k2, k1 + 1);
    fork
      issue(16'h0D80, ka);
      begin
        wait_neg(k1 + 2);
        chk_rf(1, 8'h00, "r1_before_wb");
        wait_neg(k1 + 3);
        chk_rf(1, 8'h3C, "r1_wb_k3");
        chk_rf(2, 8'h00, "r2_before_wb");
        wait_neg(k1 + 4);
        chk_rf(2, 8'h05, "r2_wb_k4");
      end
    join
    chk("add_acc_edge", ka, k2 + 4);
    chk("add_alu_a", 32'(alu_a), 'h3C);
    chk("add_alu_b", 32'(alu_b), 'h05);
    chk("add_alu_ctr", 32'(alu_ctr), 0);
    wait_neg(ka + 2);
    chk_rf(3, 8'h00, "r3_before_wb");
    wait_neg(ka + 3);
    chk_rf(3, 8'h41, "r3_wb");

    // LDI r1,0x81 ; LDI r0,0x77 ; ROL r0=r1. rb=r0 is pending but unary ops ignore rb.
    wait_neg(cyc + 2);
    issue(16'h2481, kb);
    issue(16'h2077, kc);
    issue(16'hF100, kr);
    chk("rol_acc_edge", kr, kb + 4);
    chk("rol_alu_a", 32'(alu_a), 'h81);
    chk("rol_alu_b_old", 32'(alu_b), 0);
    chk("rol_alu_ctr", 32'(alu_ctr), 'hF);
    chk_rf(0, 8'h77, "r0_ldi_wb");
    wait_neg(kr + 2);
    chk_rf(0, 8'h77, "r0_before_rol");
    wait_neg(kr + 3);
    chk_rf(0, 8'h03, "r0_rol_wb");

    // Illegal op 0101: consumed, sets sticky err, touches nothing else.
    chk("err_before_ill", 32'(err), 0);
    c0 = cyc;
    issue(16'h5000, ki);
    chk("ill_acc_edge", ki, c0 + 1);
    chk("ill_err_set", 32'(err), 1);
    chk("ill_alu_ctr_hold", 32'(alu_ctr), 'hF);
    wait_neg(ki + 5);
    chk_rf(0, 8'h03, "ill_rf0");
    chk_rf(1, 8'h81, "ill_rf1");
    chk_rf(2, 8'h05, "ill_rf2");
    chk_rf(3, 8'h41, "ill_rf3");
    chk("err_sticky", 32'(err), 1);
    chk("ill_alu_a_hold", 32'(alu_a), 'h81);

    // SUB r2=r1-r2 then reset one edge later: no writeback may survive.
    issue(16'h1980, ks);
    wait_neg(ks + 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_err", 32'(err), 0);
    chk("midrst_alu_a", 32'(alu_a), 0);
    chk_rf(1, 8'h00, "midrst_rf1");
    chk_rf(2, 8'h00, "midrst_rf2");
    @(negedge ck);
    rst_n = 1'b1;
    wait_neg(ks + 6);
    chk_rf(2, 8'h00, "sub_no_wb");
    chk_rf(3, 8'h00, "midrst_rf3");
    instr = 16'h0D80;
    instr_valid = 1'b1;
    #1;
    chk("ready_empty_sb", 32'(instr_ready), 1);
    instr_valid = 1'b0;

    // Random stream against an architectural model with stall prediction.
    for (int r = 0; r < 4; r++) begin
      mrf[r] = 8'h00;
      rdy_at[r] = 0;
    end
    stall_exp = 0;
    stall_obs = 0;
    ill_seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 9) == 0) @(negedge ck);
      op = 4'($urandom_range(0, 15));
      if (op >= 4'd3 && op <= 4'd7 && $urandom_range(0, 3) != 0) op = 4'd2;
      rd  = 2'($urandom_range(0, 3));
      ra  = 2'($urandom_range(0, 3));
      imm = 8'($urandom_range(0, 255));
      rb  = imm[7:6];
      is_alu = (op == 4'd0) || (op == 4'd1) || op[3];
      is_un  = (op >= 4'd11);
      o = cyc + 1;
      e = o;
      if (is_alu) begin
        if (rdy_at[ra] > e) e = rdy_at[ra];
        if (!is_un && rdy_at[rb] > e) e = rdy_at[rb];
      end
      issue({op, rd, ra, imm}, acc);
      chk("rnd_acc_edge", acc, e);
      stall_exp += e - o;
      stall_obs += acc - o;
      if (is_alu) begin
        chk("rnd_alu_a", 32'(alu_a), 32'(mrf[ra]));
        if (!is_un) chk("rnd_alu_b", 32'(alu_b), 32'(mrf[rb]));
        chk("rnd_alu_ctr", 32'(alu_ctr), 32'(op));
        mrf[rd] = alu_f(op, mrf[ra], mrf[rb]);
        rdy_at[rd] = e + 4;
      end else if (op == 4'd2) begin
        mrf[rd] = imm;
        rdy_at[rd] = e + 4;
      end else begin
        ill_seen = 1'b1;
      end
    end
    wait_neg(cyc + 5);
    chk_rf(0, mrf[0], "rnd_final_rf0");
    chk_rf(1, mrf[1], "rnd_final_rf1");
    chk_rf(2, mrf[2], "rnd_final_rf2");
    chk_rf(3, mrf[3], "rnd_final_rf3");
    chk("rnd_stall_total", stall_obs, stall_exp);
    chk("rnd_err", 32'(err), 32'(ill_seen));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
